// File: rtl/sonar_multi_ranger.sv
`timescale 1ns/1ps
// Round-robin HC-SR04 ranging controller for CH_NUM sensors.
// Pings one sensor at a time and converts echo width to cm, with timeout, near-alarm and nearest outputs.
module sonar_multi_ranger #(
    parameter int CH_NUM     = 2,
    parameter int CLK_MHZ    = 50,
    parameter int TRIG_US    = 10,
    parameter int US_PER_CM  = 58,
    parameter int TIMEOUT_US = 30000,
    parameter int GAP_US     = 60000,
    parameter int DIS_W      = 9,
    parameter int NEAR_CM    = 20,
    localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [CH_NUM-1:0]       echo,
    output logic [CH_NUM-1:0]       trig,
    output logic [CH_NUM*DIS_W-1:0] dis,
    output logic                    dis_valid,
    output logic [CH_W-1:0]         dis_ch,
    output logic [CH_NUM-1:0]       timeout,
    output logic [CH_NUM-1:0]       alarm,
    output logic [DIS_W-1:0]        nearest
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TRIG   = 3'd1;
    localparam logic [2:0] S_WAIT_R = 3'd2;
    localparam logic [2:0] S_MEAS   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_TOUT   = 3'd5;
    localparam logic [2:0] S_GAP    = 3'd6;

    localparam int              PS_W      = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(CLK_MHZ - 1);
    localparam logic [31:0]     TRIG_LAST = 32'(TRIG_US * CLK_MHZ - 1);
    localparam logic [31:0]     TOUT_LAST = 32'(TIMEOUT_US - 1);
    localparam logic [31:0]     GAP_LAST  = 32'(GAP_US - 1);
    localparam logic [15:0]     SUB_LAST  = 16'(US_PER_CM - 1);
    localparam logic [DIS_W-1:0] DIS_MAX  = '1;
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(CH_NUM - 1);

    logic [2:0]        state, state_nx;
    logic [CH_W-1:0]   ch, ch_nx;
    logic [31:0]       timer, timer_nx;
    logic [15:0]       sub, sub_nx;
    logic [DIS_W-1:0]  cm, cm_nx;
    logic [PS_W-1:0]   presc;
    logic              tick;
    logic              fin_ok, fin_to;
    logic [CH_NUM-1:0] echo_s1, echo_s2, echo_s3;
    logic [CH_NUM-1:0] rise, fall;
    logic [DIS_W-1:0]  d;

    // echo_s2 is the synchronised level; echo_s3 only serves edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_s1 <= '0;
            echo_s2 <= '0;
            echo_s3 <= '0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_s3 <= echo_s2;
        end
    end

    assign rise = echo_s2 & ~echo_s3;
    assign fall = ~echo_s2 & echo_s3;
    assign tick = (presc == PS_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) presc <= '0;
        else             presc <= presc + 1'b1;
    end

    // The cycle that sees the falling edge still counts, so cm covers the whole echo width
    always_comb begin
        cm_nx  = cm;
        sub_nx = sub;
        if (tick) begin
            if (sub == SUB_LAST) begin
                sub_nx = '0;
                if (cm != DIS_MAX) cm_nx = cm + 1'b1;
            end else begin
                sub_nx = sub + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        ch_nx    = ch;
        fin_ok   = 1'b0;
        fin_to   = 1'b0;
        case (state)
            S_IDLE: if (en) begin
                state_nx = S_TRIG;
                timer_nx = '0;
            end
            S_TRIG: begin
                if (timer == TRIG_LAST) begin
                    state_nx = S_WAIT_R;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            S_WAIT_R, S_MEAS: begin
                if (state == S_WAIT_R && rise[ch]) begin
                    state_nx = S_MEAS;
                    timer_nx = '0;
                end else if (state == S_MEAS && fall[ch]) begin
                    state_nx = S_DONE;
                    fin_ok   = 1'b1;
                end else if (tick) begin
                    if (timer == TOUT_LAST) begin
                        state_nx = S_TOUT;
                        fin_to   = 1'b1;
                    end else begin
                        timer_nx = timer + 1'b1;
                    end
                end
            end
            S_DONE, S_TOUT: begin
                state_nx = S_GAP;
                timer_nx = '0;
            end
            S_GAP: if (tick) begin
                if (timer == GAP_LAST) begin
                    ch_nx    = (ch == CH_LAST) ? '0 : ch + 1'b1;
                    state_nx = en ? S_TRIG : S_IDLE;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Results are written on the transition into DONE/TOUT to keep one cycle of latency
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ch        <= '0;
            timer     <= '0;
            cm        <= '0;
            sub       <= '0;
            dis       <= '1;
            timeout   <= '1;
            dis_valid <= 1'b0;
            dis_ch    <= '0;
        end else begin
            state     <= state_nx;
            ch        <= ch_nx;
            timer     <= timer_nx;
            dis_valid <= fin_ok | fin_to;
            if (state == S_WAIT_R) begin
                cm  <= '0;
                sub <= '0;
            end else if (state == S_MEAS) begin
                cm  <= cm_nx;
                sub <= sub_nx;
            end
            if (fin_ok || fin_to) begin
                dis[ch*DIS_W +: DIS_W] <= fin_ok ? cm_nx : DIS_MAX;
                timeout[ch]            <= fin_to;
                dis_ch                 <= ch;
            end
        end
    end

    always_comb begin
        trig = '0;
        if (state == S_TRIG) trig[ch] = 1'b1;
    end

    always_comb begin
        alarm   = '0;
        nearest = DIS_MAX;
        d       = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            d        = dis[i*DIS_W +: DIS_W];
            alarm[i] = ~timeout[i] & (32'(d) < 32'(NEAR_CM));
            if (!timeout[i] && d < nearest) nearest = d;
        end
    end
endmodule

// File: tb/tb_sonar_multi_ranger.sv
`timescale 1ns/1ps
// Directed bench for sonar_multi_ranger: two-channel instance plus a one-channel, 4-bit-distance instance.
module tb_sonar_multi_ranger;
    logic        clk = 1'b0;
    logic        rst, en;
    logic [1:0]  echo;
    logic [1:0]  trig;
    logic [17:0] dis;
    logic        dis_valid;
    logic [0:0]  dis_ch;
    logic [1:0]  timeout, alarm;
    logic [8:0]  nearest;

    logic        rst2, en2;
    logic [0:0]  echo2, trig2, dis_ch2, timeout2, alarm2;
    logic [3:0]  dis2, nearest2;
    logic        dis_valid2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sonar_multi_ranger #(.CH_NUM(2), .CLK_MHZ(1), .TRIG_US(10), .US_PER_CM(58),
                         .TIMEOUT_US(3000), .GAP_US(100), .DIS_W(9), .NEAR_CM(20)) dut (
        .clk(clk), .rst(rst), .en(en), .echo(echo), .trig(trig), .dis(dis),
        .dis_valid(dis_valid), .dis_ch(dis_ch), .timeout(timeout), .alarm(alarm), .nearest(nearest)
    );

    sonar_multi_ranger #(.CH_NUM(1), .CLK_MHZ(1), .TRIG_US(10), .US_PER_CM(58),
                         .TIMEOUT_US(3000), .GAP_US(100), .DIS_W(4), .NEAR_CM(20)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .echo(echo2), .trig(trig2), .dis(dis2),
        .dis_valid(dis_valid2), .dis_ch(dis_ch2), .timeout(timeout2), .alarm(alarm2), .nearest(nearest2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic driveEcho(input bit sel, input int ch, input logic lvl);
        if (sel) echo2[0] = lvl;
        else     echo[ch] = lvl;
    endtask

    // One ping: wait for trig on ch, measure it, then drive an echo of high_us cycles and wait for dis_valid.
    task automatic applyStimulus(input bit sel, input int ch, input int high_us, input bit pre_high,
                                 input int en_drop, output int lat, output int twait);
        int w, t, n;
        bit seen;
        logic cur;
        logic [1:0] others;
        lat = -1; twait = -1; w = 0; seen = 1'b0; cur = 1'b0;
        if (pre_high) driveEcho(sel, ch, 1'b1);
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            cur = sel ? trig2[0] : trig[ch];
            if (cur === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput("trig_start", 0, 1);
            return;
        end
        if (!sel) begin
            others = trig;
            others[ch] = 1'b0;
            checkOutput("trig_onehot", 32'(others), 0);
        end
        while (cur === 1'b1 && w < 50) begin
            w++;
            @(negedge clk);
            cur = sel ? trig2[0] : trig[ch];
        end
        checkOutput("trig_width", w, 10);
        t = 0;
        repeat (20) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        while ((sel ? dis_valid2 : dis_valid) !== 1'b1 && t < 8000) begin
            if (n == en_drop) en = 1'b0;
            driveEcho(sel, ch, pre_high || (n < high_us));
            @(negedge clk);
            n++;
            t++;
        end
        if (t >= 8000) checkOutput("valid_seen", 0, 1);
        driveEcho(sel, ch, 1'b0);
        lat   = n - high_us;
        twait = t;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, tw, cnt_trig, cnt_valid;
        bit seen;
        rst = 1'b1; en = 1'b0; echo = '0;
        rst2 = 1'b1; en2 = 1'b0; echo2 = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst_trig", 32'(trig), 0);
        checkOutput("rst_dis", 32'(dis), 32'h3FFFF);
        checkOutput("rst_timeout", 32'(timeout), 3);
        checkOutput("rst_valid", 32'(dis_valid), 0);
        checkOutput("rst_dis_ch", 32'(dis_ch), 0);
        checkOutput("rst_alarm", 32'(alarm), 0);
        checkOutput("rst_nearest", 32'(nearest), 511);
        checkOutput("rst2_dis", 32'(dis2), 15);
        checkOutput("rst2_nearest", 32'(nearest2), 15);

        rst = 1'b0; en = 1'b1;

        applyStimulus(0, 0, 580, 0, -1, lat, tw);
        checkOutput("p1_dis0", 32'(dis[8:0]), 10);
        checkOutput("p1_dis_ch", 32'(dis_ch), 0);
        checkOutput("p1_timeout", 32'(timeout), 2);
        checkOutput("p1_alarm", 32'(alarm), 1);
        checkOutput("p1_nearest", 32'(nearest), 10);
        checkOutput("p1_latency", lat, 3);

        applyStimulus(0, 1, 1740, 0, -1, lat, tw);
        checkOutput("p2_dis1", 32'(dis[17:9]), 30);
        checkOutput("p2_dis_ch", 32'(dis_ch), 1);
        checkOutput("p2_timeout", 32'(timeout), 0);
        checkOutput("p2_alarm", 32'(alarm), 1);
        checkOutput("p2_nearest", 32'(nearest), 10);

        applyStimulus(0, 0, 637, 0, -1, lat, tw);
        checkOutput("p3_dis0_trunc", 32'(dis[8:0]), 10);
        checkOutput("p3_dis_ch_wrap", 32'(dis_ch), 0);

        applyStimulus(0, 1, 0, 0, -1, lat, tw);
        checkOutput("p4_tout_wait", tw, 3000);
        checkOutput("p4_dis1", 32'(dis[17:9]), 511);
        checkOutput("p4_timeout", 32'(timeout), 2);
        checkOutput("p4_dis_ch", 32'(dis_ch), 1);
        checkOutput("p4_alarm", 32'(alarm), 1);
        checkOutput("p4_nearest", 32'(nearest), 10);

        applyStimulus(0, 0, 638, 0, -1, lat, tw);
        checkOutput("p5_dis0", 32'(dis[8:0]), 11);
        checkOutput("p5_nearest", 32'(nearest), 11);

        applyStimulus(0, 1, 0, 1, -1, lat, tw);
        checkOutput("p6_stuck_wait", tw, 3000);
        checkOutput("p6_dis1", 32'(dis[17:9]), 511);
        checkOutput("p6_timeout", 32'(timeout), 2);

        applyStimulus(0, 0, 3050, 0, -1, lat, tw);
        checkOutput("p7_dis0", 32'(dis[8:0]), 511);
        checkOutput("p7_timeout", 32'(timeout), 3);
        checkOutput("p7_alarm", 32'(alarm), 0);
        checkOutput("p7_nearest", 32'(nearest), 511);

        applyStimulus(0, 1, 580, 0, 100, lat, tw);
        checkOutput("p8_dis1", 32'(dis[17:9]), 10);
        checkOutput("p8_dis_ch", 32'(dis_ch), 1);
        checkOutput("p8_timeout", 32'(timeout), 1);
        checkOutput("p8_alarm", 32'(alarm), 2);
        checkOutput("p8_nearest", 32'(nearest), 10);
        cnt_trig = 0; cnt_valid = 0;
        repeat (400) begin
            @(negedge clk);
            if (trig !== 2'b00) cnt_trig++;
            if (dis_valid !== 1'b0) cnt_valid++;
        end
        checkOutput("idle_no_trig", cnt_trig, 0);
        checkOutput("idle_no_valid", cnt_valid, 0);

        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (trig[0] === 1'b1) seen = 1'b1;
        end
        checkOutput("resume_trig0", 32'(seen), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_trig", 32'(trig), 0);
        @(negedge clk);
        rst = 1'b0;

        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (trig[0] === 1'b1) seen = 1'b1;
        end
        checkOutput("retrig_ch0", 32'(seen), 1);
        for (int i = 0; i < 50 && trig[0] === 1'b1; i++) @(negedge clk);
        echo[0] = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        checkOutput("rst_meas_trig", 32'(trig), 0);
        checkOutput("rst_meas_dis", 32'(dis), 32'h3FFFF);
        checkOutput("rst_meas_timeout", 32'(timeout), 3);
        checkOutput("rst_meas_alarm", 32'(alarm), 0);
        checkOutput("rst_meas_nearest", 32'(nearest), 511);
        echo[0] = 1'b0;
        cnt_valid = 0;
        repeat (20) begin
            @(negedge clk);
            if (dis_valid !== 1'b0) cnt_valid++;
        end
        checkOutput("rst_meas_no_valid", cnt_valid, 0);
        rst = 1'b0;

        rst2 = 1'b0; en2 = 1'b1;
        applyStimulus(1, 0, 1740, 0, -1, lat, tw);
        checkOutput("s1_dis_sat", 32'(dis2), 15);
        checkOutput("s1_timeout", 32'(timeout2), 0);
        checkOutput("s1_alarm", 32'(alarm2), 1);
        checkOutput("s1_nearest", 32'(nearest2), 15);
        checkOutput("s1_latency", lat, 3);
        applyStimulus(1, 0, 580, 0, -1, lat, tw);
        checkOutput("s2_dis", 32'(dis2), 10);
        checkOutput("s2_dis_ch", 32'(dis_ch2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
